mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Uses one shift-add or restoring-divide step per cycle, then a final sign-fix cycle.
module mult_div_unit #(
  parameter int SIZE  = 32,
  parameter int CNT_W = $clog2(SIZE) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_b,
  input  logic            i_hi_we,
  input  logic            i_lo_we,
  input  logic [SIZE-1:0] i_wdata,
  output logic [SIZE-1:0] o_hi,
  output logic [SIZE-1:0] o_lo,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_div_by_zero
);

  localparam int PW = 2 * SIZE;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            r_state;
  logic [1:0]        r_op;
  logic              r_sign_a;
  logic              r_sign_b;
  logic              r_bzero;
  logic [CNT_W-1:0]  r_cnt;
  logic [SIZE-1:0]   r_hi_p;
  logic [SIZE-1:0]   r_lo_p;
  logic [SIZE-1:0]   r_opb;

  function automatic logic [SIZE-1:0] neg_if(input logic [SIZE-1:0] v, input logic neg);
    logic signed [SIZE-1:0] s;
    s = v;
    return neg ? -s : s;
  endfunction

  function automatic logic [PW-1:0] neg_if_wide(input logic [PW-1:0] v, input logic neg);
    logic signed [PW-1:0] s;
    s = v;
    return neg ? -s : s;
  endfunction

  logic            w_signed_in;
  logic [SIZE-1:0] w_mag_a;
  logic [SIZE-1:0] w_mag_b;
  logic [SIZE:0]   w_madd;
  logic [SIZE:0]   w_shift;
  logic [SIZE-1:0] w_diff;
  logic            w_ge;
  logic            w_neg_res;
  logic            w_neg_rem;
  logic [PW-1:0]   w_prod;
  logic [SIZE-1:0] w_quo;
  logic [SIZE-1:0] w_rem;

  assign w_signed_in = ~i_op[0];
  assign w_mag_a     = neg_if(i_a, w_signed_in & i_a[SIZE-1]);
  assign w_mag_b     = neg_if(i_b, w_signed_in & i_b[SIZE-1]);

  // Multiply: r_hi_p accumulates, r_lo_p holds the multiplier and fills with product bits.
  assign w_madd  = {1'b0, r_hi_p} + ({1'b0, r_opb} & {(SIZE+1){r_lo_p[0]}});

  // Divide: r_hi_p is the partial remainder, r_lo_p shifts dividend out and quotient in.
  // The low SIZE bits of the difference are exact whenever the subtraction is kept.
  assign w_shift = {r_hi_p, r_lo_p[SIZE-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opb});
  assign w_diff  = w_shift[SIZE-1:0] - r_opb;

  assign w_neg_res = ~r_op[0] & (r_sign_a ^ r_sign_b);
  assign w_neg_rem = ~r_op[0] & r_sign_a;
  assign w_prod    = neg_if_wide({r_hi_p, r_lo_p}, w_neg_res);
  assign w_quo     = neg_if(r_lo_p, w_neg_res);
  assign w_rem     = neg_if(r_hi_p, w_neg_rem);

  assign o_busy = (r_state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_op          <= '0;
      r_sign_a      <= 1'b0;
      r_sign_b      <= 1'b0;
      r_bzero       <= 1'b0;
      r_cnt         <= '0;
      r_hi_p        <= '0;
      r_lo_p        <= '0;
      r_opb         <= '0;
      o_hi          <= '0;
      o_lo          <= '0;
      o_done        <= 1'b0;
      o_div_by_zero <= 1'b0;
    end else if (!i_stall) begin
      case (r_state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_op          <= i_op;
            r_sign_a      <= i_a[SIZE-1];
            r_sign_b      <= i_b[SIZE-1];
            r_bzero       <= (i_b == '0);
            r_opb         <= i_op[1] ? w_mag_b : w_mag_a;
            r_lo_p        <= i_op[1] ? w_mag_a : w_mag_b;
            r_hi_p        <= '0;
            r_cnt         <= CNT_W'(SIZE);
            o_div_by_zero <= 1'b0;
            r_state       <= RUN;
          end else begin
            if (i_hi_we) o_hi <= i_wdata;
            if (i_lo_we) o_lo <= i_wdata;
          end
        end
        RUN: begin
          if (r_op[1]) begin
            r_hi_p <= w_ge ? w_diff : w_shift[SIZE-1:0];
            r_lo_p <= {r_lo_p[SIZE-2:0], w_ge};
          end else begin
            r_hi_p <= w_madd[SIZE:1];
            r_lo_p <= {w_madd[0], r_lo_p[SIZE-1:1]};
          end
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= FIX;
        end
        FIX: begin
          if (r_op[1]) begin
            o_lo          <= r_bzero ? '1 : w_quo;
            o_hi          <= w_rem;
            o_div_by_zero <= r_bzero;
          end else begin
            o_hi <= w_prod[PW-1:SIZE];
            o_lo <= w_prod[SIZE-1:0];
          end
          o_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
